// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter with fixed-priority or round-robin selection.
// The grant is held until acked or withdrawn by its requester.
module prio_arbiter_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] ptr
);

  typedef enum logic {IDLE, GRANT} state_e;

  typedef struct packed {
    logic         found;
    logic [W-1:0] idx;
  } pick_t;

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [N-1:0] ONE  = N'(1);

  state_e       state_q, state_d;
  logic         gnt_valid_q, gnt_valid_d;
  logic [W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0] gnt_onehot_q, gnt_onehot_d;
  logic [W-1:0] ptr_q, ptr_d;

  // Later loop iterations override earlier ones, so the
  // scan order is arranged so the preferred source comes last.
  function automatic pick_t pick(
    input logic [N-1:0] r,
    input logic         m,
    input logic [W-1:0] p
  );
    pick_t        res;
    int           t;
    logic [W-1:0] j;
    res = '0;
    if (!m) begin
      for (int k = 0; k < N; k++) begin
        j = W'(k);
        if (r[j]) begin
          res.found = 1'b1;
          res.idx   = j;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        t = int'(p) - k;
        if (t < 0) t = t + N;
        j = W'(t);
        if (r[j]) begin
          res.found = 1'b1;
          res.idx   = j;
        end
      end
    end
    return res;
  endfunction

  pick_t        win;
  logic [W-1:0] ptr_nxt;
  logic [N-1:0] req_m;

  always_comb begin
    state_d      = state_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    ptr_d        = ptr_q;
    ptr_nxt      = ptr_q;
    req_m        = req;
    win          = '0;
    unique case (state_q)
      IDLE: begin
        win = pick(req, mode, ptr_q);
        if (win.found) begin
          state_d      = GRANT;
          gnt_valid_d  = 1'b1;
          gnt_idx_d    = win.idx;
          gnt_onehot_d = ONE << win.idx;
        end
      end
      GRANT: begin
        if (ack) begin
          if (mode) begin
            ptr_nxt = (gnt_idx_q == '0) ? LAST
                                        : gnt_idx_q - 1'b1;
          end
          ptr_d = ptr_nxt;
          req_m = req & ~gnt_onehot_q;
          win   = pick(req_m, mode, ptr_nxt);
          if (win.found) begin
            gnt_idx_d    = win.idx;
            gnt_onehot_d = ONE << win.idx;
          end else begin
            state_d      = IDLE;
            gnt_valid_d  = 1'b0;
            gnt_idx_d    = '0;
            gnt_onehot_d = '0;
          end
        end else if (!req[gnt_idx_q]) begin
          state_d      = IDLE;
          gnt_valid_d  = 1'b0;
          gnt_idx_d    = '0;
          gnt_onehot_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      ptr_q        <= LAST;
    end else begin
      state_q      <= state_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      ptr_q        <= ptr_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;
  assign ptr        = ptr_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Scoreboard bench for prio_arbiter_rr: stimulus queues the expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_prio_arbiter_rr;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic         mode = 1'b0;
  logic         ack = 1'b0;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  logic [W-1:0] ptr;

  prio_arbiter_rr #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .ack        (ack),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .ptr        (ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] idx;
    logic [N-1:0] oh;
    logic [W-1:0] p;
    int           id;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h",
               nm, id, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt_valid", e.id, 32'(gnt_valid), 32'(e.v));
      chk("gnt_idx", e.id, 32'(gnt_idx), 32'(e.idx));
      chk("gnt_onehot", e.id, 32'(gnt_onehot), 32'(e.oh));
      chk("ptr", e.id, 32'(ptr), 32'(e.p));
    end
  end

  // Drive inputs for one cycle; queue the outputs expected after it.
  task automatic step(input logic [N-1:0] r, input logic m,
                      input logic a, input logic ev,
                      input int ei, input int ep);
    exp_t e;
    req  = r;
    mode = m;
    ack  = a;
    e.v   = ev;
    e.idx = W'(ei);
    e.oh  = ev ? (N'(1) << ei) : '0;
    e.p   = W'(ep);
    e.id  = step_id++;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d left expected 0", exp_q.size());
    end
  endtask

  initial begin
    // Async reset with all requests high
    req = 8'hFF;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", -1, 32'(gnt_valid), 0);
    chk("rst_idx", -1, 32'(gnt_idx), 0);
    chk("rst_onehot", -1, 32'(gnt_onehot), 0);
    chk("rst_ptr", -1, 32'(ptr), 7);
    #19 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(8'h00, 0, 0, 0, 0, 7);

    // Fixed priority sweep
    for (int k = 0; k < N; k++) begin
      step(N'(1) << k, 0, 0, 1, k, 7);
      step(8'h00, 0, 1, 0, 0, 7);
    end
    step(8'hC0, 0, 0, 1, 7, 7);
    step(8'h00, 0, 1, 0, 0, 7);
    step(8'hA0, 0, 0, 1, 7, 7);
    step(8'h00, 0, 1, 0, 0, 7);

    // Hold and withdraw
    step(8'h14, 0, 0, 1, 4, 7);
    step(8'h94, 0, 0, 1, 4, 7);
    step(8'h84, 0, 0, 0, 0, 7);
    step(8'h84, 0, 0, 1, 7, 7);
    step(8'h00, 0, 1, 0, 0, 7);

    // Round-robin fairness, back-to-back acks
    step(8'hFF, 1, 0, 1, 7, 7);
    for (int k = 6; k >= 0; k--) step(8'hFF, 1, 1, 1, k, k);
    step(8'hFF, 1, 1, 1, 7, 7);
    step(8'h00, 1, 1, 0, 0, 6);

    // Round-robin skip and wrap
    step(8'h08, 1, 0, 1, 3, 6);
    step(8'h88, 1, 1, 1, 7, 2);
    step(8'h88, 1, 1, 1, 3, 6);
    step(8'h00, 1, 1, 0, 0, 2);

    // Ack while idle is ignored; mode 0 keeps ptr
    step(8'h00, 1, 1, 0, 0, 2);
    step(8'h05, 0, 0, 1, 2, 2);
    step(8'h00, 0, 1, 0, 0, 2);

    // Reset in the middle of a grant
    step(8'h20, 1, 0, 1, 5, 2);
    @(negedge clk);
    #1;
    chk("pre_rst_idx", -2, 32'(gnt_idx), 5);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", -2, 32'(gnt_valid), 0);
    chk("mid_rst_onehot", -2, 32'(gnt_onehot), 0);
    chk("mid_rst_ptr", -2, 32'(ptr), 7);
    req  = 8'h21;
    mode = 1'b1;
    ack  = 1'b0;
    #1 rst_n = 1'b1;
    step(8'h21, 1, 0, 1, 5, 7);
    step(8'h00, 1, 1, 0, 0, 4);

    drain();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim time expired expected finish");
    $fatal(1);
  end

endmodule
